// File: rtl/mem_subword_unit_if.sv
// Bus bundle between the datapath/RAM side (master) and mem_subword_unit (slave).
// Start is a strobe accepted only when Busy is low; Done and AddrErr are single-cycle pulses.
interface mem_subword_unit_if #(
  parameter int ADDR_W = 32
);
  logic              Start;
  logic              Write;
  logic [1:0]        Size;
  logic              Unsigned;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WData;
  logic [31:0]       RData;
  logic              Done;
  logic              Busy;
  logic              AddrErr;
  logic [ADDR_W-3:0] MemAddr;
  logic              MemRd;
  logic              MemWr;
  logic [31:0]       MemWData;
  logic [31:0]       MemRData;

  modport master (
    output Start, Write, Size, Unsigned, Addr, WData, MemRData,
    input  RData, Done, Busy, AddrErr, MemAddr, MemRd, MemWr, MemWData
  );

  modport slave (
    input  Start, Write, Size, Unsigned, Addr, WData, MemRData,
    output RData, Done, Busy, AddrErr, MemAddr, MemRd, MemWr, MemWData
  );
endinterface

// File: rtl/mem_subword_unit.sv
// Big-endian byte/half/word load-store adapter in front of a word-wide synchronous RAM.
// Subword stores run read-modify-write; loads are lane-selected and sign/zero-extended.
module mem_subword_unit #(
  parameter int ADDR_W = 32
) (
  input  logic                 CLK,
  input  logic                 Reset,
  mem_subword_unit_if.slave    bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    MERGE     = 3'd2,
    WRITE     = 3'd3,
    LOAD_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              uns_q, uns_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              misaligned;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       load_ext;
  logic [31:0]       merged;

  assign misaligned = (bus.Size == 2'd3) ||
                      ((bus.Size == 2'd1) && bus.Addr[0]) ||
                      ((bus.Size == 2'd2) && (bus.Addr[1:0] != 2'b00));

  // Lane extraction and insertion both key off the latched address; offset 0 is bits 31:24.
  always_comb begin
    byte_lane = 8'h00;
    half_lane = bus.MemRData[31:16];
    load_ext  = bus.MemRData;
    merged    = bus.MemRData;
    case (addr_q[1:0])
      2'd0:    byte_lane = bus.MemRData[31:24];
      2'd1:    byte_lane = bus.MemRData[23:16];
      2'd2:    byte_lane = bus.MemRData[15:8];
      default: byte_lane = bus.MemRData[7:0];
    endcase
    if (addr_q[1]) begin
      half_lane = bus.MemRData[15:0];
    end
    case (size_q)
      2'd0: begin
        load_ext = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
        case (addr_q[1:0])
          2'd0:    merged[31:24] = wdata_q[7:0];
          2'd1:    merged[23:16] = wdata_q[7:0];
          2'd2:    merged[15:8]  = wdata_q[7:0];
          default: merged[7:0]   = wdata_q[7:0];
        endcase
      end
      2'd1: begin
        load_ext = {{16{half_lane[15] & ~uns_q}}, half_lane};
        if (addr_q[1]) begin
          merged[15:0] = wdata_q;
        end else begin
          merged[31:16] = wdata_q;
        end
      end
      default: begin
        load_ext = bus.MemRData;
        merged   = bus.MemRData;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    write_d     = write_q;
    uns_d       = uns_q;
    rdata_d     = rdata_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          addr_d  = bus.Addr;
          wdata_d = bus.WData[15:0];
          size_d  = bus.Size;
          write_d = bus.Write;
          uns_d   = bus.Unsigned;
          if (misaligned) begin
            err_d = 1'b1;
          end else if (bus.Write && (bus.Size == 2'd2)) begin
            // Word stores skip the read; the full word is staged straight away.
            mem_wdata_d = bus.WData;
            state_d     = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = write_q ? MERGE : LOAD_DONE;
      end
      LOAD_DONE: begin
        rdata_d = load_ext;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      MERGE: begin
        mem_wdata_d = merged;
        state_d     = WRITE;
      end
      WRITE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      write_q     <= 1'b0;
      uns_q       <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      write_q     <= write_d;
      uns_q       <= uns_d;
      rdata_q     <= rdata_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.RData    = rdata_q;
  assign bus.Done     = done_q;
  assign bus.AddrErr  = err_q;
  assign bus.Busy     = (state_q != IDLE);
  assign bus.MemRd    = (state_q == READ);
  assign bus.MemWr    = (state_q == WRITE);
  assign bus.MemAddr  = addr_q[ADDR_W-1:2];
  assign bus.MemWData = mem_wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_subword_unit.sv
// Bench for mem_subword_unit: behavioural synchronous RAM, per-request cycle trace,
// expected-value queue filled at issue time and drained when the DUT responds.
module tb_mem_subword_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  dbg_state;
  logic [31:0] mem [0:15];

  mem_subword_unit_if #(.ADDR_W(32)) bus ();

  mem_subword_unit #(.ADDR_W(32)) dut (
    .CLK       (clk),
    .Reset     (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.MemRd) bus.MemRData <= mem[bus.MemAddr[3:0]];
    if (bus.MemWr) mem[bus.MemAddr[3:0]] <= bus.MemWData;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] last_rdata;

  // Per-request trace, cycle numbers relative to the Start cycle T
  int rd_cnt, wr_cnt, done_cnt, err_cnt, both_cnt, busy_cnt;
  int rd_cyc, wr_cyc, done_cyc, err_cyc;
  logic [29:0] rd_addr, wr_addr;
  logic [31:0] wr_data, done_rdata, post_rst_rdata;
  logic        post_rst_busy;

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ncyc, input int restart_k, input int reset_k);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0; busy_cnt = 0;
    rd_cyc = 0; wr_cyc = 0; done_cyc = 0; err_cyc = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; done_rdata = '0;
    post_rst_rdata = 32'hxxxx_xxxx; post_rst_busy = 1'bx;
    @(negedge clk);
    bus.Write = wr; bus.Size = sz; bus.Unsigned = uns; bus.Addr = a; bus.WData = wd;
    bus.Start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (bus.MemRd) begin rd_cnt++; rd_cyc = k; rd_addr = bus.MemAddr; end
      if (bus.MemWr) begin wr_cnt++; wr_cyc = k; wr_addr = bus.MemAddr; wr_data = bus.MemWData; end
      if (bus.Done) begin done_cnt++; done_cyc = k; done_rdata = bus.RData; end
      if (bus.AddrErr) begin err_cnt++; err_cyc = k; end
      if (bus.Done && bus.AddrErr) both_cnt++;
      if (bus.Busy) busy_cnt++;
      if (k == reset_k + 1) begin post_rst_rdata = bus.RData; post_rst_busy = bus.Busy; end
      bus.Start = (k == restart_k);
      rst = (k == reset_k);
    end
    bus.Start = 1'b0;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [1:0] off);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> ((3 - off) * 8)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> ((1 - off[1]) * 16)) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin
      sh = (3 - off) * 8;   mask = 32'hFF << sh;
    end else if (sz == 2'd1) begin
      sh = (1 - off[1]) * 16; mask = 32'hFFFF << sh;
    end else begin
      sh = 0; mask = 32'hFFFF_FFFF;
    end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic test_reset();
    bus.Start = 1'b0; bus.Write = 1'b0; bus.Size = 2'd0; bus.Unsigned = 1'b0;
    bus.Addr = '0; bus.WData = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.RData !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", bus.RData, 32'h0); end
    checks++; if (bus.MemWData !== 32'h0) begin errors++; $display("FAIL reset_memwdata: got %h expected %h", bus.MemWData, 32'h0); end
    checks++; if ({bus.Done, bus.AddrErr, bus.Busy, bus.MemRd, bus.MemWr} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", {bus.Done, bus.AddrErr, bus.Busy, bus.MemRd, bus.MemWr}, 5'b0); end
    rst = 1'b0;
    last_rdata = 32'h0;
  endtask

  task automatic test_word_store(input logic [31:0] a, input logic [31:0] wd);
    exp_q.push_back(wd);
    issue(1'b1, 2'd2, 1'b0, a, wd, 5, 0, 0);
    exp = exp_q.pop_front();
    checks++; if (wr_data !== exp) begin errors++; $display("FAIL sw_data: got %h expected %h", wr_data, exp); end
    checks++; if (wr_addr !== a[31:2]) begin errors++; $display("FAIL sw_addr: got %h expected %h", wr_addr, a[31:2]); end
    checks++; if ({wr_cyc, wr_cnt, rd_cnt, done_cyc, done_cnt} !== {32'd1, 32'd1, 32'd0, 32'd2, 32'd1}) begin
      errors++; $display("FAIL sw_timing: got wr@%0d x%0d rd x%0d done@%0d x%0d expected wr@1 x1 rd x0 done@2 x1",
                         wr_cyc, wr_cnt, rd_cnt, done_cyc, done_cnt); end
    checks++; if (bus.RData !== last_rdata) begin errors++; $display("FAIL sw_rdata_hold: got %h expected %h", bus.RData, last_rdata); end
  endtask

  task automatic do_load(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    issue(1'b0, sz, uns, a, 32'h0, 5, 0, 0);
    exp = exp_q.pop_front();
    checks++; if (done_rdata !== exp) begin errors++; $display("FAIL load_data a=%h sz=%0d u=%0d: got %h expected %h", a, sz, uns, done_rdata, exp); end
    checks++; if ({rd_cyc, rd_cnt, wr_cnt, done_cyc, done_cnt} !== {32'd1, 32'd1, 32'd0, 32'd3, 32'd1}) begin
      errors++; $display("FAIL load_timing: got rd@%0d x%0d wr x%0d done@%0d x%0d expected rd@1 x1 wr x0 done@3 x1",
                         rd_cyc, rd_cnt, wr_cnt, done_cyc, done_cnt); end
    checks++; if (rd_addr !== a[31:2]) begin errors++; $display("FAIL load_memaddr: got %h expected %h", rd_addr, a[31:2]); end
    last_rdata = exp;
  endtask

  task automatic do_sub_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] e);
    exp_q.push_back(e);
    issue(1'b1, sz, 1'b0, a, wd, 6, 0, 0);
    exp = exp_q.pop_front();
    checks++; if (wr_data !== exp) begin errors++; $display("FAIL sub_store_data a=%h sz=%0d: got %h expected %h", a, sz, wr_data, exp); end
    checks++; if ({rd_cyc, wr_cyc, wr_cnt, done_cyc, done_cnt} !== {32'd1, 32'd3, 32'd1, 32'd4, 32'd1}) begin
      errors++; $display("FAIL sub_store_timing: got rd@%0d wr@%0d x%0d done@%0d x%0d expected rd@1 wr@3 x1 done@4 x1",
                         rd_cyc, wr_cyc, wr_cnt, done_cyc, done_cnt); end
    checks++; if (bus.RData !== last_rdata) begin errors++; $display("FAIL sub_store_rdata_hold: got %h expected %h", bus.RData, last_rdata); end
  endtask

  task automatic test_loads();
    test_word_store(32'h10, 32'h8899_AABB);
    test_word_store(32'h14, 32'hDEAD_BEEF);
    do_load(2'd0, 1'b0, 32'h11, 32'hFFFF_FF99);
    do_load(2'd0, 1'b1, 32'h11, 32'h0000_0099);
    do_load(2'd1, 1'b1, 32'h12, 32'h0000_AABB);
    do_load(2'd1, 1'b0, 32'h10, 32'hFFFF_8899);
    do_load(2'd0, 1'b0, 32'h13, 32'hFFFF_FFBB);
    do_load(2'd0, 1'b0, 32'h10, 32'hFFFF_FF88);
    do_load(2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF);
  endtask

  task automatic test_subword_stores();
    do_sub_store(2'd0, 32'h13, 32'h1234_5678, 32'h8899_AA78);
    test_word_store(32'h10, 32'h8899_AABB);
    do_sub_store(2'd1, 32'h10, 32'h0000_CAFE, 32'hCAFE_AABB);
    do_load(2'd2, 1'b0, 32'h10, 32'hCAFE_AABB);
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
    logic        wr [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] ad [3] = '{32'h11, 32'h12, 32'h10};
    for (int i = 0; i < 3; i++) begin
      issue(wr[i], sz[i], 1'b0, ad[i], 32'h5555_5555, 5, 0, 0);
      checks++; if ({err_cyc, err_cnt} !== {32'd1, 32'd1}) begin
        errors++; $display("FAIL misaligned_err %0d: got err@%0d x%0d expected err@1 x1", i, err_cyc, err_cnt); end
      checks++; if ({rd_cnt, wr_cnt, done_cnt, busy_cnt} !== 128'd0) begin
        errors++; $display("FAIL misaligned_quiet %0d: got rd %0d wr %0d done %0d busy %0d expected all 0", i, rd_cnt, wr_cnt, done_cnt, busy_cnt); end
      checks++; if (bus.RData !== last_rdata) begin errors++; $display("FAIL misaligned_rdata_hold %0d: got %h expected %h", i, bus.RData, last_rdata); end
    end
  endtask

  task automatic test_reset_mid_store();
    test_word_store(32'h10, 32'h8899_AABB);
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h1234_5678, 6, 0, 2);
    checks++; if ({wr_cnt, done_cnt} !== 64'd0) begin errors++; $display("FAIL rst_no_write: got wr %0d done %0d expected 0 0", wr_cnt, done_cnt); end
    checks++; if (post_rst_busy !== 1'b0) begin errors++; $display("FAIL rst_idle: got busy %b expected %b", post_rst_busy, 1'b0); end
    checks++; if (post_rst_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected %h", post_rst_rdata, 32'h0); end
    last_rdata = 32'h0;
    do_load(2'd2, 1'b0, 32'h10, 32'h8899_AABB);
  endtask

  task automatic test_busy_ignored();
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 7, 1, 0);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_one_done: got %0d expected %0d", done_cnt, 1); end
    checks++; if ({rd_cnt, busy_cnt} !== {32'd1, 32'd2}) begin errors++; $display("FAIL busy_profile: got rd %0d busy %0d expected rd 1 busy 2", rd_cnt, busy_cnt); end
    checks++; if (done_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL busy_data: got %h expected %h", done_rdata, 32'hDEAD_BEEF); end
    last_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 8, 3, 0);
    checks++; if ({done_cnt, rd_cnt, done_cyc} !== {32'd2, 32'd2, 32'd6}) begin
      errors++; $display("FAIL b2b_accept: got done x%0d rd x%0d last done@%0d expected done x2 rd x2 last done@6", done_cnt, rd_cnt, done_cyc); end
    checks++; if (done_rdata !== 32'h0000_0099) begin errors++; $display("FAIL b2b_data: got %h expected %h", done_rdata, 32'h0000_0099); end
    last_rdata = 32'h0000_0099;
  endtask

  task automatic test_random();
    logic [31:0] w, wd, a;
    logic [1:0]  sz;
    logic        uns;
    for (int i = 0; i < 12; i++) begin
      w = $urandom;
      test_word_store(32'h18, w);
      sz  = 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a   = 32'h18 | ((sz == 2'd0) ? 32'($urandom_range(0, 3)) : (sz == 2'd1) ? 32'($urandom_range(0, 1) * 2) : 32'h0);
      do_load(sz, uns, a, ref_load(w, sz, uns, a[1:0]));
      sz = 2'($urandom_range(0, 1));
      a  = 32'h18 | ((sz == 2'd0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1) * 2));
      wd = $urandom;
      do_sub_store(sz, a, wd, ref_store(w, sz, a[1:0], wd));
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_subword_stores();
    test_misaligned();
    test_reset_mid_store();
    test_busy_ignored();
    test_back_to_back();
    test_random();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected %0d", exp_q.size(), 0); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
